mc_req_arbiter: RTL



---
 rtl/mc_req_arbiter_pkg.sv | 33 +++
 rtl/mc_req_arbiter_if.sv | 32 +++
 rtl/mc_req_arbiter_rr_pick.sv | 30 +++
 rtl/mc_req_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mc_req_arbiter_pkg.sv
// Shared types and constants for the memory-controller request arbiter.
package mc_req_arbiter_pkg;

  localparam int unsigned MC_PKT_W     = 42;
  localparam int unsigned MC_VALID     = 41;
  localparam int unsigned MC_WRITE     = 40;
  localparam int unsigned MC_CADDR_HI  = 39;
  localparam int unsigned MC_CADDR_LO  = 30;
  localparam int unsigned MC_MADDR_HI  = 29;
  localparam int unsigned MC_MADDR_LO  = 0;
  localparam int unsigned MC_PAYLOAD_W = 41;
  localparam int unsigned PROGRESS_W   = 10;

  // Packet body below the valid bit, as held in a requester slot.
  typedef struct packed {
    logic                           write;
    logic [MC_CADDR_HI:MC_CADDR_LO] caddr;
    logic [MC_MADDR_HI:MC_MADDR_LO] maddr;
  } mc_payload_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACTIVE
  } arb_state_e;

  // Requester-ID width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mc_req_arbiter_if.sv
// Requester-side and MC-side signals of the request arbiter.
interface mc_req_arbiter_if
  import mc_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [NUM_REQ*MC_PKT_W-1:0] IN_req;
  logic [NUM_REQ-1:0]          OUT_busy;
  logic [PROGRESS_W-1:0]       OUT_progress;
  logic [MC_PKT_W-1:0]         OUT_MC_if;
  logic [ID_W-1:0]             OUT_MC_reqID;
  logic [ID_W-1:0]             OUT_owner;
  logic                        OUT_timeoutErr;
  logic                        IN_MC_busy;
  logic [PROGRESS_W-1:0]       IN_MC_progress;

  // Arbiter side.
  modport slave (
    input  IN_req, IN_MC_busy, IN_MC_progress,
    output OUT_busy, OUT_progress, OUT_MC_if, OUT_MC_reqID, OUT_owner, OUT_timeoutErr
  );

  // Requesters plus memory controller side.
  modport master (
    output IN_req, IN_MC_busy, IN_MC_progress,
    input  OUT_busy, OUT_progress, OUT_MC_if, OUT_MC_reqID, OUT_owner, OUT_timeoutErr
  );

endinterface

// File: rtl/mc_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer.
module mc_req_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    grant_c_o,
  output logic               any_c_o
);

  int unsigned idx;

  // Walk from farthest to nearest so the slot closest to the pointer wins.
  always_comb begin
    grant_c_o = '0;
    any_c_o   = |req_i;
    idx       = 0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      idx = 32'(ptr_i) + 32'(k);
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (req_i[idx[ID_W-1:0]]) begin
        grant_c_o = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mc_req_arbiter.sv
// Shares the single MC request port between NUM_REQ cache requesters.
module mc_req_arbiter
  import mc_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            rst,
  mc_req_arbiter_if.slave arb_if
);

  localparam int unsigned ID_W = id_width(NUM_REQ);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  full_q, full_d;
  mc_payload_t         slot_q [NUM_REQ];
  mc_payload_t         slot_d [NUM_REQ];
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [MC_PKT_W-1:0] mc_pkt_q, mc_pkt_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  req_valid;
  logic [NUM_REQ-1:0]  owner_active;
  logic [NUM_REQ-1:0]  accept;
  logic [NUM_REQ-1:0]  busy_c;
  mc_payload_t         req_payload [NUM_REQ];
  logic [ID_W-1:0]     grant;
  logic                grant_any;

  mc_req_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_i     (full_q),
    .ptr_i     (rr_ptr_q),
    .grant_c_o (grant),
    .any_c_o   (grant_any)
  );

  // Per-requester decode and private busy view.
  always_comb begin
    req_valid    = '0;
    owner_active = '0;
    accept       = '0;
    busy_c       = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_valid[i]    = arb_if.IN_req[MC_PKT_W*i + MC_VALID];
      req_payload[i]  = arb_if.IN_req[MC_PKT_W*i +: MC_PAYLOAD_W];
      owner_active[i] = (state_q != IDLE) && (owner_q == ID_W'(i));
      accept[i]       = !full_q[i] && !owner_active[i];
      busy_c[i]       = full_q[i] | owner_active[i] | ((state_q == IDLE) & arb_if.IN_MC_busy);
    end
  end

  // Slot capture, grant/issue sequencing and transfer watchdog.
  always_comb begin
    state_d  = state_q;
    full_d   = full_q;
    slot_d   = slot_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    mc_pkt_d = mc_pkt_q;
    wdog_d   = wdog_q;
    err_d    = err_q;

    // Control bits live for the ISSUE cycle only; the address stays.
    mc_pkt_d[MC_VALID] = 1'b0;
    mc_pkt_d[MC_WRITE] = 1'b0;

    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_valid[i] && accept[i]) begin
        full_d[i] = 1'b1;
        slot_d[i] = req_payload[i];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (grant_any && !arb_if.IN_MC_busy) begin
          state_d       = ISSUE;
          full_d[grant] = 1'b0;
          mc_pkt_d      = {1'b1, slot_q[grant]};
          owner_d       = grant;
          rr_ptr_d      = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        state_d = ACTIVE;
        wdog_d  = '0;
      end
      ACTIVE: begin
        if (!arb_if.IN_MC_busy) begin
          state_d = IDLE;
        end
        if (wdog_q != WD_W'(TIMEOUT)) begin
          wdog_d = wdog_q + WD_W'(1);
          if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      full_q   <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        slot_q[i] <= '0;
      end
      rr_ptr_q <= '0;
      owner_q  <= '0;
      mc_pkt_q <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      slot_q   <= slot_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      mc_pkt_q <= mc_pkt_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
    end
  end

  assign arb_if.OUT_busy       = busy_c;
  assign arb_if.OUT_progress   = arb_if.IN_MC_progress;
  assign arb_if.OUT_MC_if      = mc_pkt_q;
  assign arb_if.OUT_MC_reqID   = owner_q;
  assign arb_if.OUT_owner      = owner_q;
  assign arb_if.OUT_timeoutErr = err_q;

  // A requester must not fire while its busy view says slot full or transfer owned.
  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_proto_chk
    a_no_overrun: assert property (@(posedge clk) disable iff (rst) !(req_valid[g] && !accept[g]));
  end

endmodule
